regfile_writeback_queue: RTL and testbench

Write-side companion of the 32x32 register bank: collects results from the ALU and the data-memory load path and serializes them onto the bank's single write port (`di`/`dir`/`ena`), one write per cycle. Buffers up to DEPTH pending writes when both producers fire together or the write port is stalled. Exposes a pending-write lookup so the read side can forward values not yet committed to the bank.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/wb_entry_fifo.sv | 70 +++++++
 rtl/regfile_writeback_queue.sv | 126 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the 32x32 register bank and its write-back queue.
//   DATA_W / ADDR_W : register data and address widths
//   ZERO_REG        : hard-wired zero register; writes to it are dropped
//   wb_entry_t      : one pending bank write {dir, data}, same layout as the
//                     bank write port
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] dir;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] dir);
      return dir == ZERO_REG;
   endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// wb_entry_fifo
// Circular buffer of pending register writes with two push ports per cycle.
// When both pushes fire, entry0 lands first (older) and entry1 right after it.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears storage too)
//   i_push0 / i_entry0    first (older) push
//   i_push1 / i_entry1    second push
//   i_pop                 drop head entry (caller guarantees non-empty)
//   o_count               number of valid entries, 0..DEPTH
//   o_head                index of the oldest entry
//   o_entries             raw storage, for the forwarding search
module wb_entry_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push0,
   input  wb_entry_t        i_entry0,
   input  logic             i_push1,
   input  wb_entry_t        i_entry1,
   input  logic             i_pop,
   output logic [CNT_W-1:0] o_count,
   output logic [PTR_W-1:0] o_head,
   output wb_entry_t        o_entries [DEPTH]
);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [PTR_W-1:0] w_tail_p1;
   logic [PTR_W-1:0] w_slot1;

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign w_tail_p1 = r_tail + PTR_W'(1);
   assign w_slot1   = i_push0 ? w_tail_p1 : r_tail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push0) begin
            r_mem[r_tail] <= i_entry0;
         end
         if (i_push1) begin
            r_mem[w_slot1] <= i_entry1;
         end
         r_tail <= r_tail + PTR_W'(i_push0) + PTR_W'(i_push1);
         if (i_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
      end
   end

   assign o_count   = r_count;
   assign o_head    = r_head;
   assign o_entries = r_mem;

endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Collects ALU and load results and serializes them onto the register bank's
// single write port, one write per unstalled cycle. Pending writes can be
// looked up by the read side for forwarding.
// DATA_W / ADDR_W come from regfile_pkg because the entry layout is shared
// with the bank's write port.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alu_valid/ready/dir/data         ALU result handshake
//   mem_valid/ready/dir/data         load result handshake
//   wb_stall                         bank write port unavailable
//   wb_ena, wb_dir, wb_di            bank write port
//   ra1, ra2                         read addresses to look up
//   hit1/fwd1, hit2/fwd2             newest pending write to ra1/ra2
module regfile_writeback_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_dir,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_dir,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_stall,
   output logic              wb_ena,
   output logic [ADDR_W-1:0] wb_dir,
   output logic [DATA_W-1:0] wb_di,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              hit1,
   output logic              hit2,
   output logic [DATA_W-1:0] fwd1,
   output logic [DATA_W-1:0] fwd2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(DEPTH - 1);

   logic [CNT_W-1:0] w_count;
   logic [PTR_W-1:0] w_head;
   wb_entry_t        w_entries [DEPTH];
   wb_entry_t        w_head_entry;
   wb_entry_t        w_alu_entry;
   wb_entry_t        w_mem_entry;

   logic w_alu_live;
   logic w_push0;
   logic w_push1;
   logic w_nonempty;
   logic w_pop;

   // Readiness looks only at the registered count, never at this cycle's pop,
   // so there is no path from wb_stall into the producers' handshakes.
   // An ALU result to the zero register never occupies a slot, so it does not
   // steal the last free entry from the load path.
   assign w_alu_live = alu_valid && !is_zero_reg(alu_dir);
   assign alu_ready  = (w_count < C_FULL);
   assign mem_ready  = (w_count < C_FULL_M1) ||
                       ((w_count == C_FULL_M1) && !w_alu_live);

   // Handshakes to the zero register complete but are discarded here.
   assign w_push0 = alu_valid && alu_ready && !is_zero_reg(alu_dir);
   assign w_push1 = mem_valid && mem_ready && !is_zero_reg(mem_dir);

   assign w_alu_entry = '{dir: alu_dir, data: alu_data};
   assign w_mem_entry = '{dir: mem_dir, data: mem_data};

   assign w_nonempty = (w_count != '0);
   assign w_pop      = w_nonempty && !wb_stall;

   wb_entry_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push0   (w_push0),
      .i_entry0  (w_alu_entry),
      .i_push1   (w_push1),
      .i_entry1  (w_mem_entry),
      .i_pop     (w_pop),
      .o_count   (w_count),
      .o_head    (w_head),
      .o_entries (w_entries)
   );

   assign w_head_entry = w_entries[w_head];

   assign wb_ena = w_pop;
   assign wb_dir = w_nonempty ? w_head_entry.dir  : '0;
   assign wb_di  = w_nonempty ? w_head_entry.data : '0;

   // Walk valid entries oldest to newest; a later match overwrites an earlier
   // one, so the newest pending write to an address wins. The head entry is
   // included even while it is being written this cycle.
   always_comb begin
      logic [PTR_W-1:0] v_idx;
      hit1  = 1'b0;
      hit2  = 1'b0;
      fwd1  = '0;
      fwd2  = '0;
      v_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_idx = w_head + PTR_W'(i);
         if (CNT_W'(i) < w_count) begin
            if (!is_zero_reg(ra1) && (w_entries[v_idx].dir == ra1)) begin
               hit1 = 1'b1;
               fwd1 = w_entries[v_idx].data;
            end
            if (!is_zero_reg(ra2) && (w_entries[v_idx].dir == ra2)) begin
               hit2 = 1'b1;
               fwd2 = w_entries[v_idx].data;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_dir = '0;
   logic [31:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [4:0]  mem_dir = '0;
   logic [31:0] mem_data = '0;
   logic        wb_stall = 1'b0;
   logic        wb_ena;
   logic [4:0]  wb_dir;
   logic [31:0] wb_di;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic        hit1, hit2;
   logic [31:0] fwd1, fwd2;

   int n_vec = 0;
   int n_err = 0;

   regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_dir   (alu_dir),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_dir   (mem_dir),
      .mem_data  (mem_data),
      .wb_stall  (wb_stall),
      .wb_ena    (wb_ena),
      .wb_dir    (wb_dir),
      .wb_di     (wb_di),
      .ra1       (ra1),
      .ra2       (ra2),
      .hit1      (hit1),
      .hit2      (hit2),
      .fwd1      (fwd1),
      .fwd2      (fwd2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain queue of pending writes, oldest at index 0.
   typedef struct {
      logic [4:0]  dir;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];

   function automatic void mlook(input logic [4:0] ra, output logic h, output logic [31:0] f);
      h = 1'b0;
      f = '0;
      if (ra != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dir == ra) begin
               h = 1'b1;
               f = mq[i].data;
               break;
            end
         end
      end
   endfunction

   logic        e_ar, e_mr, e_ena, e_h1, e_h2, a_live, a_acc, m_acc;
   logic [4:0]  e_dir;
   logic [31:0] e_di, e_f1, e_f2;
   int          sz;

   always begin
      @(negedge clk);
      if (!rst_n) mq.delete();
      sz     = mq.size();
      a_live = alu_valid && (alu_dir != 5'd0);
      e_ar   = (sz < DEPTH);
      e_mr   = (sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !a_live);
      e_ena  = (sz > 0) && !wb_stall;
      e_dir  = (sz > 0) ? mq[0].dir : 5'd0;
      e_di   = (sz > 0) ? mq[0].data : 32'd0;
      mlook(ra1, e_h1, e_f1);
      mlook(ra2, e_h2, e_f2);
      chk("m_alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
      chk("m_mem_ready", {31'd0, mem_ready}, {31'd0, e_mr});
      chk("m_wb_ena", {31'd0, wb_ena}, {31'd0, e_ena});
      chk("m_wb_dir", {27'd0, wb_dir}, {27'd0, e_dir});
      chk("m_wb_di", wb_di, e_di);
      chk("m_hit1", {31'd0, hit1}, {31'd0, e_h1});
      chk("m_fwd1", fwd1, e_f1);
      chk("m_hit2", {31'd0, hit2}, {31'd0, e_h2});
      chk("m_fwd2", fwd2, e_f2);
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
      end else begin
         sz     = mq.size();
         a_live = alu_valid && (alu_dir != 5'd0);
         a_acc  = alu_valid && (sz < DEPTH);
         m_acc  = mem_valid && ((sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !a_live));
         if ((sz > 0) && !wb_stall) mq.delete(0);
         if (a_acc && (alu_dir != 5'd0)) mq.push_back('{dir: alu_dir, data: alu_data});
         if (m_acc && (mem_dir != 5'd0)) mq.push_back('{dir: mem_dir, data: mem_data});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(posedge clk);
      #3;
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
      chk("rst_wb_ena", {31'd0, wb_ena}, 32'd0);
      chk("rst_wb_di", wb_di, 32'd0);
      cyc();
      rst_n = 1'b1;

      // single ALU write, one-cycle latency
      cyc();
      alu_valid = 1'b1; alu_dir = 5'd5; alu_data = 32'hDEADBEEF;
      #2 chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0; ra1 = 5'd5;
      #2;
      chk("t1_wb_ena", {31'd0, wb_ena}, 32'd1);
      chk("t1_wb_dir", {27'd0, wb_dir}, 32'd5);
      chk("t1_wb_di", wb_di, 32'hDEADBEEF);
      chk("t1_head_hit", {31'd0, hit1}, 32'd1);
      chk("t1_head_fwd", fwd1, 32'hDEADBEEF);
      cyc();
      ra1 = 5'd0;
      #2;
      chk("t1_empty_ena", {31'd0, wb_ena}, 32'd0);
      chk("t1_empty_dir", {27'd0, wb_dir}, 32'd0);

      // ALU and load in the same cycle: ALU first
      cyc();
      alu_valid = 1'b1; alu_dir = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_dir = 5'd4; mem_data = 32'h22;
      #2 chk("t2_mem_ready", {31'd0, mem_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0; mem_valid = 1'b0;
      #2;
      chk("t2_first_dir", {27'd0, wb_dir}, 32'd3);
      chk("t2_first_di", wb_di, 32'h11);
      cyc();
      #2;
      chk("t2_second_ena", {31'd0, wb_ena}, 32'd1);
      chk("t2_second_dir", {27'd0, wb_dir}, 32'd4);
      chk("t2_second_di", wb_di, 32'h22);
      cyc();
      #2 chk("t2_done_ena", {31'd0, wb_ena}, 32'd0);

      // stalled fill: 6 offered, 4 accepted, then in-order drain
      cyc();
      wb_stall = 1'b1;
      for (int k = 0; k < 6; k++) begin
         alu_valid = 1'b1; alu_dir = 5'(10 + k); alu_data = 32'h100 + 32'(k);
         #2 chk("t3_fill_ready", {31'd0, alu_ready}, (k < 4) ? 32'd1 : 32'd0);
         cyc();
      end
      alu_valid = 1'b0; ra1 = 5'd11;
      #2;
      chk("t3_full_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("t3_full_mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("t3_stall_ena", {31'd0, wb_ena}, 32'd0);
      chk("t3_stall_dir", {27'd0, wb_dir}, 32'd10);
      chk("t3_stall_hit", {31'd0, hit1}, 32'd1);
      chk("t3_stall_fwd", fwd1, 32'h101);
      cyc();
      wb_stall = 1'b0; ra1 = 5'd0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("t3_drain_ena", {31'd0, wb_ena}, 32'd1);
         chk("t3_drain_dir", {27'd0, wb_dir}, 32'(10 + i));
         chk("t3_drain_di", wb_di, 32'h100 + 32'(i));
         cyc();
      end
      #2;
      chk("t3_after_ena", {31'd0, wb_ena}, 32'd0);
      chk("t3_after_ready", {31'd0, alu_ready}, 32'd1);

      // zero-register ALU write frees the last slot for the load
      cyc();
      wb_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_dir = 5'(20 + k); alu_data = 32'h200 + 32'(k);
         cyc();
      end
      alu_dir = 5'd1; mem_valid = 1'b0;
      #2 chk("t4_m1_live_mem_ready", {31'd0, mem_ready}, 32'd0);
      #1;
      alu_dir = 5'd0; alu_data = 32'hFFFF;
      mem_valid = 1'b1; mem_dir = 5'd7; mem_data = 32'h77;
      #1;
      chk("t4_m1_zero_mem_ready", {31'd0, mem_ready}, 32'd1);
      chk("t4_m1_alu_ready", {31'd0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0; mem_valid = 1'b0;
      #2;
      chk("t4_full_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("t4_full_mem_ready", {31'd0, mem_ready}, 32'd0);
      cyc();
      wb_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("t4_drain_ena", {31'd0, wb_ena}, 32'd1);
         chk("t4_drain_dir", {27'd0, wb_dir}, (i < 3) ? 32'(20 + i) : 32'd7);
         chk("t4_drain_di", wb_di, (i < 3) ? 32'h200 + 32'(i) : 32'h77);
         cyc();
      end
      #2 chk("t4_after_ena", {31'd0, wb_ena}, 32'd0);

      // newest-first forwarding
      cyc();
      wb_stall = 1'b1;
      alu_valid = 1'b1; alu_dir = 5'd9; alu_data = 32'hA;
      cyc();
      alu_data = 32'hB;
      cyc();
      alu_valid = 1'b0; ra1 = 5'd9; ra2 = 5'd0;
      #2;
      chk("t5_hit1", {31'd0, hit1}, 32'd1);
      chk("t5_fwd1", fwd1, 32'hB);
      chk("t5_hit2", {31'd0, hit2}, 32'd0);
      chk("t5_fwd2", fwd2, 32'd0);
      cyc();
      wb_stall = 1'b0; ra1 = 5'd0;
      #2 chk("t5_drain_first", wb_di, 32'hA);
      cyc();
      #2 chk("t5_drain_second", wb_di, 32'hB);
      cyc();
      #2 chk("t5_after_ena", {31'd0, wb_ena}, 32'd0);

      // reset in the middle of a drain
      cyc();
      wb_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_dir = 5'(1 + k); alu_data = 32'h31 + 32'(k);
         cyc();
      end
      alu_valid = 1'b0; wb_stall = 1'b0;
      #2;
      chk("t6_drain_ena", {31'd0, wb_ena}, 32'd1);
      chk("t6_drain_dir", {27'd0, wb_dir}, 32'd1);
      cyc();
      #2 chk("t6_drain_dir2", {27'd0, wb_dir}, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ena", {31'd0, wb_ena}, 32'd0);
      chk("t6_rst_dir", {27'd0, wb_dir}, 32'd0);
      chk("t6_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("t6_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
      cyc();
      #2 chk("t6_rst_hold_ena", {31'd0, wb_ena}, 32'd0);
      cyc();
      rst_n = 1'b1;
      #2;
      chk("t6_post_ena", {31'd0, wb_ena}, 32'd0);
      chk("t6_post_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("t6_post_mem_ready", {31'd0, mem_ready}, 32'd1);
      cyc();
      #2 chk("t6_post_ena2", {31'd0, wb_ena}, 32'd0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
